// File: rtl/cam_capture_crop.sv
// OV7670 capture front end: decodes vsync/href/byte stream into RGB565 pixels,
// tracks x/y and writes an aligned square crop window into the frame buffer.
module cam_capture_crop #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned WIN_X0   = 0,
  parameter int unsigned WIN_Y0   = 0,
  parameter int unsigned WIN_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [7:0]            data_wires,
  output logic                  p_valid,
  output logic [15:0]           p_data,
  output logic                  w_en_a,
  output logic [2*WIN_LOG2-1:0] w_addr,
  output logic [15:0]           d_in_a,
  output logic                  f_done,
  output logic                  err_sync
);

  localparam int unsigned XW      = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW      = $clog2(V_ACTIVE + 1);
  localparam int unsigned XYW     = (XW > YW) ? XW : YW;
  localparam int unsigned CW      = (XYW > WIN_LOG2) ? XYW : WIN_LOG2;
  localparam int unsigned WinSize = 32'd1 << WIN_LOG2;

  typedef enum logic [1:0] {StWaitVs, StVsHigh, StActive} state_e;

  state_e          state_q;
  logic [CW-1:0]   x_q, y_q;
  logic            phase_q;
  logic            href_d_q;
  logic            frame_en_q;
  logic [7:0]      hi_q;

  logic                  in_win;
  logic                  line_end;
  logic                  x_full;
  logic                  y_full;
  logic [2*WIN_LOG2-1:0] addr_next;

  // Unsigned wrap makes x < WIN_X0 land far above WinSize, so one compare covers both bounds.
  assign in_win    = ((32'(x_q) - WIN_X0) < WinSize) && ((32'(y_q) - WIN_Y0) < WinSize);
  assign addr_next = {WIN_LOG2'(y_q - CW'(WIN_Y0)), WIN_LOG2'(x_q - CW'(WIN_X0))};
  assign x_full    = (x_q == CW'(H_ACTIVE));
  assign y_full    = (y_q == CW'(V_ACTIVE));
  // A vsync rise with href still high closes the line in the same cycle.
  assign line_end  = (href_d_q && !href) || (vsync && href);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StWaitVs;
      x_q        <= '0;
      y_q        <= '0;
      phase_q    <= 1'b0;
      href_d_q   <= 1'b0;
      frame_en_q <= 1'b0;
      hi_q       <= '0;
      p_valid    <= 1'b0;
      p_data     <= '0;
      w_en_a     <= 1'b0;
      w_addr     <= '0;
      d_in_a     <= '0;
      f_done     <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      href_d_q <= href;
      p_valid  <= 1'b0;
      w_en_a   <= 1'b0;
      f_done   <= 1'b0;
      case (state_q)
        StWaitVs: begin
          if (vsync) state_q <= StVsHigh;
        end
        StVsHigh: begin
          if (!vsync) begin
            x_q        <= '0;
            y_q        <= '0;
            phase_q    <= 1'b0;
            frame_en_q <= write;
            state_q    <= StActive;
          end
        end
        StActive: begin
          if (line_end) begin
            x_q     <= '0;
            phase_q <= 1'b0;
            if (x_q != '0 && !y_full) y_q <= y_q + CW'(1);
            if (phase_q) err_sync <= 1'b1;
          end else if (href && !vsync) begin
            if (!href_d_q && y_full) err_sync <= 1'b1;
            if (!phase_q) begin
              hi_q    <= data_wires;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              p_valid <= 1'b1;
              p_data  <= {hi_q, data_wires};
              d_in_a  <= {hi_q, data_wires};
              if (x_full) begin
                err_sync <= 1'b1;
              end else begin
                x_q    <= x_q + CW'(1);
                w_en_a <= frame_en_q && in_win;
                w_addr <= addr_next;
              end
            end
          end
          if (vsync) begin
            f_done  <= 1'b1;
            state_q <= StVsHigh;
          end
        end
        default: state_q <= StWaitVs;
      endcase
    end
  end

endmodule
